register_bank: RTL and testbench

Parametrised multi-port register bank for the CPU datapath: one write port, two registered read ports and a per-register busy scoreboard, all in a single clock domain. It generalises the single 32-bit datapath register into a WIDTH x DEPTH array with optional hardwired-zero register 0. It sits between decode (read ports, reservations) and writeback (write port).

---
 rtl/register_bank.sv | 102 ++++++++++
 tb/tb_register_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// rtl/register_bank.sv - WIDTH x DEPTH register bank: one write port, two registered read ports, busy scoreboard.
// Optional REGISTER_BANK_BYPASS_EN: a same-edge write is forwarded to a read of the same address.
module register_bank #(
    parameter int              WIDTH       = 32,
    parameter int              DEPTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              ZERO_REG    = 1,
    localparam int             AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    ra_addr,
    input  logic             re_b,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic [AW:0]      busy_cnt
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             wr_en;
    logic             rsv_en;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [WIDTH-1:0] rd_a_val;
    logic [WIDTH-1:0] rd_b_val;

    function automatic logic [WIDTH-1:0] read_value(input logic [AW-1:0] addr);
        if (ZERO_REG != 0 && addr == '0)
            return '0;
`ifdef REGISTER_BANK_BYPASS_EN
        if (wr_en && waddr == addr)
            return wdata;
`endif
        return regs[addr];
    endfunction

    always_comb begin
        wr_en     = we && !(ZERO_REG != 0 && waddr == '0);
        rsv_en    = rsv && !(ZERO_REG != 0 && rsv_addr == '0);
        busy_next = busy;
        if (we)
            busy_next[waddr] = 1'b0;
        // Reservation wins over a same-edge write: the new producer owns the register.
        if (rsv_en)
            busy_next[rsv_addr] = 1'b1;
        cnt_inc  = rsv_en && !busy[rsv_addr];
        cnt_dec  = we && busy[waddr] && !(rsv_en && rsv_addr == waddr);
        rd_a_val = read_value(ra_addr);
        rd_b_val = read_value(rb_addr);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RESET_VALUE;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ra_data <= '0;
            rb_data <= '0;
        end else begin
            if (re_a)
                ra_data <= rd_a_val;
            if (re_b)
                rb_data <= rd_b_val;
        end
    end

    // busy_cnt tracks popcount(busy) incrementally rather than summing the vector.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_next;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_cnt <= busy_cnt + (AW+1)'(1);
                2'b01:   busy_cnt <= busy_cnt - (AW+1)'(1);
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

    assign busy_a = busy[ra_addr];
    assign busy_b = busy[rb_addr];

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - randomized self-checking bench for register_bank against a behavioural model.
module tb_register_bank;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RV    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        we = 1'b0, re_a = 1'b0, re_b = 1'b0, rsv = 1'b0;
    logic [3:0]  waddr = '0, ra_addr = '0, rb_addr = '0, rsv_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] ra_data, rb_data;
    logic        busy_a, busy_b;
    logic [4:0]  busy_cnt;

    register_bank #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV), .ZERO_REG(1)
    ) dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .ra_addr(ra_addr), .re_b(re_b), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data), .rsv(rsv), .rsv_addr(rsv_addr),
        .busy_a(busy_a), .busy_b(busy_b), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_regs [DEPTH];
    bit          m_busy [DEPTH];
    logic [31:0] m_ra, m_rb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_read(input int a, input bit w, input int wa, input logic [31:0] wd);
        if (a == 0)
            return 32'h0;
`ifdef REGISTER_BANK_BYPASS_EN
        if (w && wa == a)
            return wd;
`endif
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = (i == 0) ? 32'h0 : RV;
            m_busy[i] = 1'b0;
        end
        m_ra = '0;
        m_rb = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ra_data"}, ra_data, m_ra);
        check({tag, ".rb_data"}, rb_data, m_rb);
        check({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(m_count()));
        check({tag, ".busy_a"}, 32'(busy_a), 32'(m_busy[ra_addr]));
        check({tag, ".busy_b"}, 32'(busy_b), 32'(m_busy[rb_addr]));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic cycle(input bit w, input int wa, input logic [31:0] wd,
                         input bit ea, input int aa, input bit eb, input int ab,
                         input bit r, input int rsa, input string tag);
        we = w; waddr = 4'(wa); wdata = wd;
        re_a = ea; ra_addr = 4'(aa); re_b = eb; rb_addr = 4'(ab);
        rsv = r; rsv_addr = 4'(rsa);
        @(posedge clk);
        if (clr) begin
            if (ea) m_ra = m_read(aa, w, wa, wd);
            if (eb) m_rb = m_read(ab, w, wa, wd);
            if (w && wa != 0) m_regs[wa] = wd;
            if (w) m_busy[wa] = 1'b0;
            if (r && rsa != 0) m_busy[rsa] = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        m_reset();
        #1;
        check("reset.ra_data", ra_data, 32'h0);
        check("reset.busy_cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        clr = 1'b1;

        cycle(1, 3, 32'h1234_5678, 0, 0, 0, 0, 0, 0, "wr3");
        cycle(0, 0, 0, 1, 3, 0, 0, 0, 0, "rd3");
        check("rd3.value", ra_data, 32'h1234_5678);
        cycle(1, 3, 32'h0BAD_0BAD, 0, 3, 0, 0, 0, 0, "hold");
        check("hold.value", ra_data, 32'h1234_5678);

        cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, "zero_wr");
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, "zero_rd");
        check("zero.rb_data", rb_data, 32'h0);
        check("zero.busy_cnt", 32'(busy_cnt), 32'h0);

        cycle(0, 0, 0, 0, 0, 0, 0, 1, 2, "rsv2");
        check("sb.cnt1", 32'(busy_cnt), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, "rsv7");
        check("sb.cnt2", 32'(busy_cnt), 32'd2);
        cycle(0, 0, 0, 0, 7, 0, 0, 1, 9, "rsv9");
        check("sb.cnt3", 32'(busy_cnt), 32'd3);
        check("sb.busy7", 32'(busy_a), 32'd1);
        cycle(1, 7, 32'h77, 0, 7, 0, 2, 0, 0, "wr7");
        check("sb.cnt_after_wr7", 32'(busy_cnt), 32'd2);
        check("sb.busy_a7", 32'(busy_a), 32'd0);
        cycle(1, 2, 32'h22, 0, 7, 0, 2, 1, 2, "rsvwr2");
        check("sb.busy2_kept", 32'(busy_b), 32'd1);
        check("sb.cnt_kept", 32'(busy_cnt), 32'd2);

        cycle(1, 4, 32'hA, 0, 0, 0, 0, 0, 0, "byp_pre");
        cycle(1, 4, 32'hB, 1, 4, 1, 4, 0, 0, "byp");
`ifdef REGISTER_BANK_BYPASS_EN
        check("bypass.ra", ra_data, 32'hB);
`else
        check("bypass.ra", ra_data, 32'hA);
`endif

        for (int i = 1; i < DEPTH; i++)
            cycle(0, 0, 0, 0, 0, 0, 0, 1, i, "fill");
        check("fill.cnt", 32'(busy_cnt), 32'd15);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, "fill_extra");
        check("fill.extra", 32'(busy_cnt), 32'd15);
        for (int i = 0; i < DEPTH; i++)
            cycle(1, i, 32'(i * 3), 0, 0, 0, 0, 0, 0, "drain");
        check("drain.cnt", 32'(busy_cnt), 32'd0);

        cycle(0, 0, 0, 1, 6, 1, 9, 1, 11, "pre_rst");
        #3;
        clr = 1'b0;
        m_reset();
        #1;
        check("async.ra_data", ra_data, 32'h0);
        check("async.rb_data", rb_data, 32'h0);
        check("async.busy_cnt", 32'(busy_cnt), 32'h0);
        check("async.busy_b", 32'(busy_b), 32'h0);
        cycle(1, 5, 32'h5555, 1, 5, 0, 0, 1, 5, "in_reset");
        #2;
        clr = 1'b1;
        cycle(0, 0, 0, 1, 5, 1, 0, 0, 0, "post_rst");
        check("post.reg5", ra_data, RV);
        check("post.reg0", rb_data, 32'h0);

        for (int n = 0; n < 400; n++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)), "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
